// File: rtl/enc_pkg.sv
// Shared SECDED definitions for the encoder pipeline and its matching decoder.
// Mode encoding, per-mode widths and the info-bit-to-Hamming-position map.
package enc_pkg;

    typedef enum logic [1:0] {
        MOD_4_4     = 2'b00,
        MOD_11_5    = 2'b01,
        MOD_26_6    = 2'b10,
        MOD_ILLEGAL = 2'b11
    } mode_t;

    localparam int INFO_W   [3] = '{4, 11, 26};
    localparam int PARITY_W [3] = '{4, 5, 6};
    localparam int FULL_W   [3] = '{8, 16, 32};

    // Widest mode needs r-1 = 5 positional Hamming bits.
    localparam int HAM_W = 5;

    // Position of info bit idx: the idx-th position that is not a power of two.
    function automatic int hamming_pos(input int idx);
        int cnt;
        int pos_r;
        cnt   = 0;
        pos_r = 0;
        for (int p = 3; p < 64; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos_r = p;
                cnt++;
            end
        end
        return pos_r;
    endfunction

    function automatic logic [31:0] info_mask(input mode_t m);
        logic [31:0] msk;
        case (m)
            MOD_4_4:  msk = 32'((64'd1 << INFO_W[0]) - 64'd1);
            MOD_11_5: msk = 32'((64'd1 << INFO_W[1]) - 64'd1);
            MOD_26_6: msk = 32'((64'd1 << INFO_W[2]) - 64'd1);
            default:  msk = '0;
        endcase
        return msk;
    endfunction

endpackage

// File: rtl/enc_hamming_calc.sv
// Combinational positional Hamming bits p[0..r-2] for an already-masked info word.
module enc_hamming_calc
    import enc_pkg::*;
#(
    parameter int MAX_INFO_WIDTH = 26
) (
    input  logic [MAX_INFO_WIDTH-1:0] info,
    input  logic [1:0]                mod,
    output logic [HAM_W-1:0]          ham
);

    always_comb begin
        ham = '0;
        for (int j = 0; j < HAM_W; j++) begin
            for (int i = 0; i < MAX_INFO_WIDTH; i++) begin
                if (((hamming_pos(i) >> j) & 1) != 0) ham[j] = ham[j] ^ info[i];
            end
        end
        // Narrow modes never reach the upper positions; force them clean anyway.
        case (mode_t'(mod))
            MOD_4_4:  ham[HAM_W-1:3] = '0;
            MOD_11_5: ham[HAM_W-1:4] = '0;
            default:  ;
        endcase
    end

endmodule

// File: rtl/enc_pipe.sv
// Two-stage streaming SECDED encoder with valid/ready backpressure.
// Optional error injection on the packed codeword when ENC_ERR_INJECT_EN is defined.
module enc_pipe
    import enc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    mod_out,
    output logic                          mod_err,
    output logic [CNT_WIDTH-1:0]          word_cnt
`ifdef ENC_ERR_INJECT_EN
    ,
    input  logic [MAX_CODEWORD_WIDTH-1:0] err_mask
`endif
);

    logic                          s1_valid;
    logic [MAX_INFO_WIDTH-1:0]     s1_info;
    logic [1:0]                    s1_mod;
    logic [HAM_W-1:0]              s1_ham;
    logic                          s2_valid;
    logic [MAX_CODEWORD_WIDTH-1:0] s2_data;
    logic [1:0]                    s2_mod;
    logic                          s2_err;
    logic [CNT_WIDTH-1:0]          cnt;

    logic [31:0]                   mask_full;
    logic [MAX_INFO_WIDTH-1:0]     in_info;
    logic [HAM_W-1:0]              in_ham;
    logic [MAX_CODEWORD_WIDTH-1:0] cw;
    logic                          overall;
    logic                          out_xfer;
    logic                          s2_load;
    logic                          s1_advance;

`ifdef ENC_ERR_INJECT_EN
    logic [MAX_CODEWORD_WIDTH-1:0] s1_mask;
    logic [MAX_CODEWORD_WIDTH-1:0] full_mask;
`endif

    assign out_xfer   = s2_valid && out_ready;
    assign s2_load    = !s2_valid || out_xfer;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = rst && (!s1_valid || s1_advance);

    assign mask_full = info_mask(mode_t'(mod));
    assign in_info   = data_in & mask_full[MAX_INFO_WIDTH-1:0];

    enc_hamming_calc #(
        .MAX_INFO_WIDTH(MAX_INFO_WIDTH)
    ) u_ham (
        .info(in_info),
        .mod (mod),
        .ham (in_ham)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_info  <= '0;
            s1_mod   <= '0;
            s1_ham   <= '0;
`ifdef ENC_ERR_INJECT_EN
            s1_mask  <= '0;
`endif
        end else if (!s1_valid || s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_info <= in_info;
                s1_mod  <= mod;
                s1_ham  <= in_ham;
`ifdef ENC_ERR_INJECT_EN
                s1_mask <= err_mask;
`endif
            end
        end
    end

    // Info and parity are already masked, so the overall bit is a plain reduction.
    always_comb begin
        cw      = '0;
        overall = (^s1_info) ^ (^s1_ham);
`ifdef ENC_ERR_INJECT_EN
        full_mask = '0;
`endif
        case (mode_t'(s1_mod))
            MOD_4_4: begin
                cw[FULL_W[0]-1:0] = {s1_info[INFO_W[0]-1:0], overall, s1_ham[PARITY_W[0]-2:0]};
`ifdef ENC_ERR_INJECT_EN
                full_mask[FULL_W[0]-1:0] = '1;
`endif
            end
            MOD_11_5: begin
                cw[FULL_W[1]-1:0] = {s1_info[INFO_W[1]-1:0], overall, s1_ham[PARITY_W[1]-2:0]};
`ifdef ENC_ERR_INJECT_EN
                full_mask[FULL_W[1]-1:0] = '1;
`endif
            end
            MOD_26_6: begin
                cw[FULL_W[2]-1:0] = {s1_info[INFO_W[2]-1:0], overall, s1_ham[PARITY_W[2]-2:0]};
`ifdef ENC_ERR_INJECT_EN
                full_mask[FULL_W[2]-1:0] = '1;
`endif
            end
            default: ;
        endcase
`ifdef ENC_ERR_INJECT_EN
        cw = cw ^ (s1_mask & full_mask);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mod   <= '0;
            s2_err   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= cw;
                    s2_mod  <= s1_mod;
                    s2_err  <= (s1_mod == MOD_ILLEGAL);
                end
            end
            if (out_xfer) cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign out_valid = s2_valid;
    assign data_out  = s2_data;
    assign mod_out   = s2_mod;
    assign mod_err   = s2_err;
    assign word_cnt  = cnt;

endmodule

// File: doc/enc_pipe.md
Name: enc_pipe

Overview:
- Streaming SECDED Hamming encoder; the transmit-side counterpart of the DEC decoder.
- Accepts an info word and a mode, and emits a codeword in the exact layout DEC consumes: info in bits [full-1:parity], parity in bits [parity-1:0], zero-padded to MAX_CODEWORD_WIDTH.
- Two-stage valid/ready pipeline with full backpressure; sits between the data source and the channel/decoder.

Parameters:
- MAX_CODEWORD_WIDTH, 32, width of data_out.
- MAX_INFO_WIDTH, 26, width of data_in.
- CNT_WIDTH, 16, width of word_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- in_valid  in  1  data_in/mod valid.
- in_ready  out  1  encoder can accept this cycle.
- data_in  in  MAX_INFO_WIDTH  info word, LSB-aligned; bits above the mode's info width are ignored.
- mod  in  2  00 = 4/4, 01 = 11/5, 10 = 26/6 (info/parity); 11 is illegal.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts.
- data_out  out  MAX_CODEWORD_WIDTH  codeword, zero above the mode's full length.
- mod_out  out  2  mode travelling with the codeword.
- mod_err  out  1  current output came from mod = 11.
- word_cnt  out  CNT_WIDTH  count of codewords handed off (out_valid && out_ready); wraps.

Behaviour:
- Reset (rst = 0 at posedge), also when it occurs mid-operation:
  - Both stage valids cleared; out_valid = 0, data_out = 0, mod_out = 0, mod_err = 0, word_cnt = 0.
  - In-flight words are discarded.
  - in_ready = 0 during reset and 1 in the first cycle after.
- Handshake:
  - Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Once out_valid is asserted, data_out, mod_out and mod_err stay stable until the transfer.
- Stage 1 (S1) registers masked info, mod, and the r-1 Hamming parity bits.
- Stage 2 (S2) adds the overall parity, packs the codeword and drives the outputs.
- Latency: 2 cycles from accept to out_valid; throughput 1 word/cycle when out_ready = 1.
- Stall rules:
  - S2 loads when !s2_valid or the out transfer happens.
  - S1 loads when !s1_valid or S1 advances.
  - in_ready = !s1_valid || s1_advance, which is combinational from out_ready.
  - Simultaneous out transfer and in transfer with a full pipe: both occur with no bubble.
- Hamming bits:
  - Info bit d[i] maps to the i-th non-power-of-two position (3, 5, 6, 7, 9, ...).
  - p[j] (j = 0..r-2) = XOR of d[i] whose position has bit j set.
  - p[r-1] = XOR of all info bits and p[0..r-2] (even overall parity).
- Illegal mod = 11: the word is accepted and flows through normally, with data_out = 0, mod_out = 11, mod_err = 1; it is counted in word_cnt.
- word_cnt increments by 1 per out transfer and wraps from all-ones to 0.

Optional Feature:
- Macro ENC_ERR_INJECT_EN.
- When defined:
  - Adds input err_mask[MAX_CODEWORD_WIDTH-1:0], sampled with the input transfer and carried through S1.
  - S2 XORs it into the packed codeword; mask bits above the mode's full length are ignored.
  - Used to drive 1- and 2-bit errors into DEC.
- When undefined: the port is absent and no XOR logic exists.

Decomposition:
- Package enc_pkg holds:
  - mode_t enum (MOD_4_4, MOD_11_5, MOD_26_6, MOD_ILLEGAL).
  - localparams INFO_W[3], PARITY_W[3], FULL_W[3].
  - A function returning the Hamming position of info bit i.
- DEC will share this package.
- One combinational sub-module, enc_hamming_calc (info, mod → r-1 Hamming bits), instantiated in S1.

Test Plan:
- Reset then mod = 00, data_in = 0x1, out_ready = 1 → out_valid 2 cycles after accept, data_out = 0x0000001B, mod_err = 0, word_cnt = 1.
- mod = 00, data_in = 0xF → data_out = 0x000000FF. mod = 01, data_in = 0 → data_out = 0; every mode's output round-trips through DEC with num_of_errors = 0.
- Back-to-back 8 words with out_ready = 1 → in_ready held 1, 8 consecutive out_valid cycles. Then out_ready = 0 for 5 cycles → in_ready drops after 2 more accepts, data_out held stable, no loss or duplication on release.
- mod = 11, data_in = 0x3FFFFFF → data_out = 0, mod_out = 11, mod_err = 1, word_cnt increments.
- rst = 0 for 1 cycle with 2 words in flight → out_valid = 0 next cycle, word_cnt = 0, the words never appear. Preload word_cnt to 0xFFFF and transfer 1 word → 0x0000.
- ENC_ERR_INJECT_EN defined, mod = 10, err_mask = 0x1 → DEC corrects it, num_of_errors = 1. err_mask = 0x3 → DEC reports 2 errors.
